// File: rtl/lock_pkg.sv
// Shared definitions for the code-entry lock: FSM state encoding, attempt
// counter sizing, default digit width and a small sizing helper.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_e;

  localparam int              UA_W        = 3;
  localparam logic [UA_W-1:0] UA_MAX      = 3'd7;
  localparam int              DIGIT_W_DEF = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the open window, the lockout window and
// the optional inter-digit timeout. done is high while the count is zero.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/code_entry_ctrl.sv
// Key-entry controller: collects digits, checks them against CODE, drives
// unlock / lockout and the failed-attempt count. Macro ENTRY_TIMEOUT_EN adds
// an inter-digit timeout in ENTRY.
module code_entry_ctrl
  import lock_pkg::*;
#(
  parameter int                          DIGIT_W        = DIGIT_W_DEF,
  parameter int                          CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
  parameter int                          OPEN_CYCLES    = 50,
  parameter int                          LOCKOUT_CYCLES = 1000,
  parameter int                          TIMEOUT_CYCLES = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  input  logic               gt,
  output logic [UA_W-1:0]    ua,
  output logic               unlock,
  output logic               locked_out,
  output logic               err,
  output logic [3:0]         digits,
  output state_e             dbg_state
);

  // Key handshake: key_valid is a single-cycle strobe with no ready; a digit
  // is taken on the edge where key_valid is high in IDLE/ENTRY, else lost.

  localparam int         EW   = CODE_LEN * DIGIT_W;
  localparam int         TMAX = max3(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
  localparam int         TW   = $clog2(TMAX + 1);
  localparam logic [3:0] LEN4 = 4'(CODE_LEN);

`ifdef ENTRY_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic [3:0]        digits_q, digits_d;
  logic [UA_W-1:0]   ua_q, ua_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    digits_d = digits_q;
    ua_d     = ua_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (!key_clear && key_valid) begin
          entry_d  = (entry_q << DIGIT_W) | EW'(key_digit);
          digits_d = 4'd1;
          state_d  = (CODE_LEN == 1) ? CHECK : ENTRY;
          tmr_load = TIMEOUT_EN;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        end
      end
      ENTRY: begin
        // A full entry register commits to CHECK on the following edge.
        if (key_clear) begin
          state_d = IDLE;
        end else if (digits_q == LEN4) begin
          state_d = CHECK;
        end else if (key_valid) begin
          entry_d  = (entry_q << DIGIT_W) | EW'(key_digit);
          digits_d = digits_q + 4'd1;
          tmr_load = TIMEOUT_EN;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        end else if (TIMEOUT_EN && tmr_done) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (entry_q == CODE) begin
          ua_d     = '0;
          state_d  = OPEN;
          tmr_load = 1'b1;
          tmr_val  = TW'(OPEN_CYCLES - 1);
        end else begin
          ua_d    = (ua_q == UA_MAX) ? ua_q : ua_q + 1'b1;
          state_d = FAIL;
        end
      end
      OPEN: begin
        if (tmr_done) state_d = IDLE;
      end
      FAIL: begin
        if (gt) begin
          state_d  = LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Partial entries only live in ENTRY/CHECK; every other state sees zero.
    if (state_d != ENTRY && state_d != CHECK) begin
      entry_d  = '0;
      digits_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      digits_q <= '0;
      ua_q     <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      digits_q <= digits_d;
      ua_q     <= ua_d;
    end
  end

  assign ua         = ua_q;
  assign digits     = digits_q;
  assign unlock     = (state_q == OPEN);
  assign locked_out = (state_q == LOCKOUT);
  assign err        = (state_q == FAIL);
  assign dbg_state  = state_q;

endmodule
